// File: rtl/split_stream_out_slot.sv
// One output lane of the broadcast: a single pend bit that becomes tvalid and
// reports whether this lane is holding up the shared beat register.
module split_stream_out_slot (
  input  logic clk,
  input  logic srst,
  input  logic load,
  input  logic sel,
  input  logic tready,
  output logic tvalid,
  output logic blocking
);

  logic pend_reg;

  // A fresh load wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      pend_reg <= 1'b0;
    end else if (load) begin
      pend_reg <= sel;
    end else if (tready) begin
      pend_reg <= 1'b0;
    end
  end

  assign tvalid   = pend_reg;
  assign blocking = pend_reg & ~tready;

endmodule

// File: rtl/multi_split_stream_pkt.sv
// AXI-Stream 1-to-N fork with a registered shared beat, a per-packet enable mask
// latched at start of packet, and packet / dropped-packet counters.
module multi_split_stream_pkt #(
  parameter int WIDTH      = 16,
  parameter int USER_WIDTH = 2,
  parameter int OUTPUTS    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [WIDTH-1:0]              i_tdata,
  input  logic [USER_WIDTH-1:0]         i_tuser,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [WIDTH*OUTPUTS-1:0]      o_tdata,
  output logic [USER_WIDTH*OUTPUTS-1:0] o_tuser,
  output logic [OUTPUTS-1:0]            o_tlast,
  output logic [OUTPUTS-1:0]            o_tvalid,
  input  logic [OUTPUTS-1:0]            o_tready,
  input  logic [OUTPUTS-1:0]            en_mask,
  output logic [OUTPUTS-1:0]            active_mask,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam logic SOP = 1'b0;
  localparam logic MID = 1'b1;

  logic                  srst;
  logic                  accept;
  logic                  state_reg;
  logic [OUTPUTS-1:0]    active_mask_reg;
  logic [OUTPUTS-1:0]    pkt_mask;
  logic [OUTPUTS-1:0]    blocking;
  logic [WIDTH-1:0]      data_reg;
  logic [USER_WIDTH-1:0] user_reg;
  logic                  last_reg;
  logic [CNT_WIDTH-1:0]  pkt_count_reg;
  logic [CNT_WIDTH-1:0]  drop_count_reg;

  assign srst     = reset | clear;
  assign i_tready = ~srst & ~|blocking;
  assign accept   = i_tvalid & i_tready;
  // The first beat of a packet routes on the live request; the rest follow the latch.
  assign pkt_mask = (state_reg == SOP) ? en_mask : active_mask_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg       <= SOP;
      active_mask_reg <= '0;
      data_reg        <= '0;
      user_reg        <= '0;
      last_reg        <= 1'b0;
      pkt_count_reg   <= '0;
      drop_count_reg  <= '0;
    end else if (accept) begin
      data_reg <= i_tdata;
      user_reg <= i_tuser;
      last_reg <= i_tlast;
      if (state_reg == SOP) begin
        active_mask_reg <= en_mask;
      end
      state_reg <= i_tlast ? SOP : MID;
      if (i_tlast) begin
        pkt_count_reg <= pkt_count_reg + CNT_WIDTH'(1);
        if (pkt_mask == '0) begin
          drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_out
    split_stream_out_slot u_slot (
      .clk      (clk),
      .srst     (srst),
      .load     (accept),
      .sel      (pkt_mask[gi]),
      .tready   (o_tready[gi]),
      .tvalid   (o_tvalid[gi]),
      .blocking (blocking[gi])
    );
    assign o_tdata[WIDTH*gi +: WIDTH]           = data_reg;
    assign o_tuser[USER_WIDTH*gi +: USER_WIDTH] = user_reg;
    assign o_tlast[gi]                          = last_reg;
  end

  assign active_mask = active_mask_reg;
  assign pkt_count   = pkt_count_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_multi_split_stream_pkt.sv
// Directed bench for the packet fork: per-output expected-beat queues filled at
// accept time and drained by a handshake monitor, plus directed status checks.
module tb_multi_split_stream_pkt;

  localparam int W  = 16;
  localparam int UW = 2;
  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic            clear;
  logic [W-1:0]    i_tdata;
  logic [UW-1:0]   i_tuser;
  logic            i_tlast;
  logic            i_tvalid;
  logic            i_tready;
  logic [W*N-1:0]  o_tdata;
  logic [UW*N-1:0] o_tuser;
  logic [N-1:0]    o_tlast;
  logic [N-1:0]    o_tvalid;
  logic [N-1:0]    o_tready;
  logic [N-1:0]    en_mask;
  logic [N-1:0]    active_mask;
  logic [CW-1:0]   pkt_count;
  logic [CW-1:0]   drop_count;

  multi_split_stream_pkt #(
    .WIDTH(W), .USER_WIDTH(UW), .OUTPUTS(N), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready),
    .en_mask(en_mask), .active_mask(active_mask),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected beats per output, packed as {tuser, tlast, tdata}.
  logic [W+UW:0] exp_q [N][$];
  logic          m_mid;
  logic [N-1:0]  m_mask;
  logic [CW-1:0] m_pkt;
  logic [CW-1:0] m_drop;
  logic          rand_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mid  = 1'b0;
    m_mask = '0;
    m_pkt  = '0;
    m_drop = '0;
    for (int ii = 0; ii < N; ii++) exp_q[ii].delete();
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic [UW-1:0] u, input logic l);
    logic [N-1:0] m;
    m = m_mid ? m_mask : en_mask;
    if (!m_mid) m_mask = en_mask;
    m_mid = ~l;
    for (int ii = 0; ii < N; ii++)
      if (m[ii]) exp_q[ii].push_back({u, l, d});
    if (l) begin
      m_pkt = m_pkt + 1'b1;
      if (m == '0) m_drop = m_drop + 1'b1;
    end
  endtask

  // Starts and ends at posedge+1; holds the beat until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic [UW-1:0] u, input logic l);
    int n;
    n = 0;
    i_tdata  = d;
    i_tuser  = u;
    i_tlast  = l;
    i_tvalid = 1'b1;
    if (rand_ready) o_tready = N'($urandom);
    #1;
    while (!i_tready && n < 50) begin
      @(posedge clk);
      #1;
      if (rand_ready) o_tready = N'($urandom);
      #1;
      n++;
    end
    chk("accept_wait", {31'b0, i_tready}, 32'd1);
    if (i_tready) model_accept(d, u, l);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pkt"}, 32'(pkt_count), 32'(m_pkt));
    chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
  endtask

  // Handshakes are sampled mid-cycle; o_tready only changes just after posedge.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      for (int ii = 0; ii < N; ii++) begin
        if (o_tvalid[ii] && o_tready[ii]) begin
          chk($sformatf("out%0d_expected_beat", ii), 32'(exp_q[ii].size() > 0), 32'd1);
          if (exp_q[ii].size() > 0)
            chk($sformatf("out%0d_beat", ii),
                32'({o_tuser[UW*ii +: UW], o_tlast[ii], o_tdata[W*ii +: W]}),
                32'(exp_q[ii].pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    i_tdata = '0; i_tuser = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    o_tready = '1; en_mask = '1; rand_ready = 1'b0;
    model_reset();
    step(1);
    i_tvalid = 1'b1;
    #1;
    chk("reset_i_tready", 32'(i_tready), 32'd0);
    chk("reset_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("reset_active", 32'(active_mask), 32'd0);
    i_tvalid = 1'b0;
    step(1);
    reset = 1'b0;
    #1;
    chk("idle_i_tready", 32'(i_tready), 32'd1);

    // 1: full broadcast, 8-beat packet, one-cycle latency
    en_mask = 4'hF; o_tready = 4'hF;
    send(16'd0, 2'd1, 1'b0);
    chk("t1_latency_valid", 32'(o_tvalid), 32'hF);
    chk("t1_latency_data3", 32'(o_tdata[W*3 +: W]), 32'd0);
    for (int b = 1; b < 8; b++) send(16'(b), 2'(b), b == 7);
    chk("t1_tlast", 32'(o_tlast), 32'hF);
    chk("t1_data0", 32'(o_tdata[W*0 +: W]), 32'd7);
    step(1);
    chk("t1_drained", 32'(o_tvalid), 32'd0);
    chk("t1_pkt", 32'(pkt_count), 32'd1);

    // 2: output 2 stalls for 3 cycles
    send(16'hA0A0, 2'd2, 1'b1);
    o_tready = 4'b1011;
    #1;
    chk("t2_stall0_ready", 32'(i_tready), 32'd0);
    step(1);
    chk("t2_stall1_valid", 32'(o_tvalid), 32'b0100);
    chk("t2_stall1_ready", 32'(i_tready), 32'd0);
    chk("t2_stall1_data2", 32'(o_tdata[W*2 +: W]), 32'hA0A0);
    step(1);
    chk("t2_stall2_valid", 32'(o_tvalid), 32'b0100);
    step(1);
    o_tready = 4'hF;
    send(16'hB1B1, 2'd3, 1'b1);
    chk("t2_next_valid", 32'(o_tvalid), 32'hF);
    step(1);
    chk_counts("t2");

    // 3: mask latched at SOP, mid-packet change ignored
    en_mask = 4'b0101;
    send(16'h0300, 2'd0, 1'b0);
    chk("t3_valid", 32'(o_tvalid), 32'b0101);
    en_mask = 4'b1010;
    send(16'h0301, 2'd0, 1'b0);
    send(16'h0302, 2'd1, 1'b1);
    chk("t3_valid_last", 32'(o_tvalid), 32'b0101);
    chk("t3_active_a", 32'(active_mask), 32'b0101);
    send(16'h0310, 2'd2, 1'b0);
    chk("t3_active_b", 32'(active_mask), 32'b1010);
    send(16'h0311, 2'd3, 1'b1);
    chk("t3_valid_b", 32'(o_tvalid), 32'b1010);
    step(1);
    chk_counts("t3");

    // 4: zero mask drops but never stalls, even with o_tready low
    en_mask = '0; o_tready = '0;
    for (int b = 0; b < 5; b++) begin
      send(16'(16'h0400 + b), 2'd0, b == 4);
      chk($sformatf("t4_valid%0d", b), 32'(o_tvalid), 32'd0);
    end
    #1;
    chk("t4_ready", 32'(i_tready), 32'd1);
    chk_counts("t4");
    chk("t4_drop", 32'(drop_count), 32'd1);

    // 5: reset mid-packet with all outputs pending
    en_mask = 4'hF;
    send(16'h0500, 2'd1, 1'b0);
    chk("t5_pend", 32'(o_tvalid), 32'hF);
    reset = 1'b1;
    #1;
    chk("t5_reset_ready", 32'(i_tready), 32'd0);
    step(1);
    reset = 1'b0;
    model_reset();
    chk("t5_valid", 32'(o_tvalid), 32'd0);
    chk("t5_pkt", 32'(pkt_count), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    en_mask = 4'b0011; o_tready = 4'hF;
    send(16'h0501, 2'd2, 1'b1);
    chk("t5_new_valid", 32'(o_tvalid), 32'b0011);
    chk("t5_new_active", 32'(active_mask), 32'b0011);
    step(1);

    // 6: soft clear, then 17 single-beat packets under random backpressure
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    model_reset();
    chk("t6_clear_pkt", 32'(pkt_count), 32'd0);
    rand_ready = 1'b1;
    for (int p = 0; p < 17; p++) begin
      en_mask = N'(p % 7 + 1);
      send(16'(16'h0600 + p), 2'(p), 1'b1);
    end
    rand_ready = 1'b0;
    o_tready = 4'hF;
    step(2);
    chk("t6_pkt_wrap", 32'(pkt_count), 32'd1);
    chk_counts("t6");
    for (int ii = 0; ii < N; ii++)
      chk($sformatf("end_q%0d_empty", ii), 32'(exp_q[ii].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
